// File: rtl/feed_sequencer.sv
// ---------------------------------------------------------------------------
// feed_sequencer
//
// Loads ROWS input buffers from a single ready/valid word stream (row-major,
// k_len words per row), then replays them into a systolic array with the
// classic diagonal skew: row r reads during feed steps r .. r+k_len-1. After
// the last read the sequencer idles DRAIN_CYCLES cycles, pulses o_done for
// one cycle and returns to IDLE.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_start      start a job (only looked at in IDLE)
//   i_k_len      words per row, 1..DEPTH, sampled with i_start
//   i_ld_valid   load word valid
//   i_ld_data    load word
//   o_ld_ready   high in LOAD; word accepted on i_ld_valid && o_ld_ready
//   o_wr_en      one-hot buffer write strobe (combinational with the load word)
//   o_wr_data    buffer write data
//   o_rd_en      per-buffer skewed read strobe (registered)
//   o_busy       job in progress
//   o_done       one-cycle completion pulse
//   o_err        one-cycle pulse when a start is rejected for a bad k_len
// ---------------------------------------------------------------------------
module feed_sequencer #(
  parameter int ROWS         = 3,
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_k_len,
  input  logic                  i_ld_valid,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic                  o_ld_ready,
  output logic [ROWS-1:0]       o_wr_en,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic [ROWS-1:0]       o_rd_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int KW    = ADDR_WIDTH + 1;
  // t must hold values up to DEPTH+ROWS (used as t+2 against k_len+ROWS)
  localparam int TW    = $clog2(DEPTH + ROWS + 1);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW    = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_reg,  state_next;
  logic [KW-1:0]   k_len_reg,  k_len_next;
  logic [RW-1:0]   row_reg,    row_next;
  logic [KW-1:0]   col_reg,    col_next;
  logic [TW-1:0]   t_reg,      t_next;
  logic [DW-1:0]   drain_reg,  drain_next;
  logic [ROWS-1:0] rd_en_reg,  rd_en_next;
  logic            err_reg,    err_next;

  logic accept;
  logic k_len_ok;
  logic t_last;

  assign accept   = (state_reg == S_LOAD) && i_ld_valid;
  assign k_len_ok = (i_k_len != '0) && (i_k_len <= KW'(DEPTH));
  // last feed step is t = k_len+ROWS-2; compare as t+2 == k_len+ROWS so
  // ROWS = 1 does not need a negative constant
  assign t_last   = (t_reg + TW'(2)) == (TW'(k_len_reg) + TW'(ROWS));

  always_comb begin
    state_next = state_reg;
    k_len_next = k_len_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    t_next     = t_reg;
    drain_next = drain_reg;
    err_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          if (k_len_ok) begin
            k_len_next = i_k_len;
            row_next   = '0;
            col_next   = '0;
            t_next     = '0;
            state_next = S_LOAD;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (col_reg == k_len_reg - KW'(1)) begin
            col_next = '0;
            if (row_reg == RW'(ROWS - 1)) begin
              state_next = S_FEED;
              t_next     = '0;
            end else begin
              row_next = row_reg + RW'(1);
            end
          end else begin
            col_next = col_reg + KW'(1);
          end
        end
      end
      S_FEED: begin
        if (t_last) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_reg == DW'(DRAIN_CYCLES - 1)) begin
          state_next = S_DONE;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Read strobes are decoded from the next-cycle state and step so that the
  // registered strobe lines up with the feed step it belongs to.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi = gi + 1) begin : g_rd
      assign rd_en_next[gi] = (state_next == S_FEED) &&
                              (t_next >= TW'(gi)) &&
                              (t_next < TW'(gi) + TW'(k_len_next));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      k_len_reg <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      t_reg     <= '0;
      drain_reg <= '0;
      rd_en_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_len_reg <= k_len_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      t_reg     <= t_next;
      drain_reg <= drain_next;
      rd_en_reg <= rd_en_next;
      err_reg   <= err_next;
    end
  end

  // Write strobe follows the accepted word in the same cycle.
  generate
    for (gi = 0; gi < ROWS; gi = gi + 1) begin : g_wr
      assign o_wr_en[gi] = accept && (row_reg == RW'(gi));
    end
  endgenerate

  assign o_wr_data  = i_ld_data;
  assign o_ld_ready = (state_reg == S_LOAD);
  assign o_rd_en    = rd_en_reg;
  assign o_busy     = (state_reg != S_IDLE);
  assign o_done     = (state_reg == S_DONE);
  assign o_err      = err_reg;

endmodule

// File: tb/tb_feed_sequencer.sv
// ---------------------------------------------------------------------------
// tb_feed_sequencer
//
// Directed self-checking bench for feed_sequencer at default parameters.
// Inputs change and outputs are sampled just after the falling edge.
// ---------------------------------------------------------------------------
module tb_feed_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  k_len;
  logic        ld_valid;
  logic [23:0] ld_data;
  logic        ld_ready;
  logic [2:0]  wr_en;
  logic [23:0] wr_data;
  logic [2:0]  rd_en;
  logic        busy;
  logic        done;
  logic        err;

  int tests;
  int fails;

  feed_sequencer #(
    .ROWS(3), .DATA_WIDTH(24), .ADDR_WIDTH(2), .DRAIN_CYCLES(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k_len(k_len),
    .i_ld_valid(ld_valid), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .o_wr_en(wr_en), .o_wr_data(wr_data), .o_rd_en(rd_en),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; k_len = '0; ld_valid = 1'b0; ld_data = '0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({ld_ready, wr_en, rd_en, busy, done, err} !== 10'b0) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=0", {ld_ready, wr_en, rd_en, busy, done, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] test_reset done");
  endtask

  // k_len = 4: 12 words back-to-back, skewed feed, 2 drain cycles, done.
  task automatic test_basic;
    logic [2:0] exp_rd [6];
    exp_rd = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100};
    start = 1'b1; k_len = 3'd4;
    #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
    @(negedge clk);
    start = 1'b0;
    #1;
    tests++;
    if ({busy, ld_ready} !== 2'b11) begin
      fails++; $display("FAIL basic_load_entry got=%b want=11", {busy, ld_ready});
    end
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1; ld_data = 24'hA00000 + 24'(i);
      #1;
      tests++;
      if (wr_en !== (3'b001 << (i / 4)) || wr_data !== ld_data || rd_en !== 3'b000) begin
        fails++;
        $display("FAIL basic_wr[%0d] got wr_en=%b data=%h rd_en=%b want wr_en=%b data=%h",
                 i, wr_en, wr_data, rd_en, 3'b001 << (i / 4), ld_data);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      #1;
      tests++;
      if (rd_en !== exp_rd[t] || wr_en !== 3'b000 || ld_ready !== 1'b0) begin
        fails++;
        $display("FAIL basic_rd[t=%0d] got rd_en=%b wr_en=%b ready=%b want rd_en=%b",
                 t, rd_en, wr_en, ld_ready, exp_rd[t]);
      end
      @(negedge clk);
    end
    for (int d = 0; d < 2; d++) begin
      #1;
      tests++;
      if ({rd_en, busy, done} !== 5'b00010) begin
        fails++; $display("FAIL basic_drain[%0d] got=%b want=00010", d, {rd_en, busy, done});
      end
      @(negedge clk);
    end
    #1;
    tests++;
    if ({busy, done} !== 2'b11) begin
      fails++; $display("FAIL basic_done got=%b want=11", {busy, done});
    end
    @(negedge clk);
    #1;
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL basic_idle_after got=%b want=00", {busy, done});
    end
    $display("[TB] test_basic done");
  endtask

  // k_len = 1: one word per row, diagonal single-step reads.
  task automatic test_k1;
    logic [2:0] exp_rd [3];
    exp_rd = '{3'b001, 3'b010, 3'b100};
    @(negedge clk);
    start = 1'b1; k_len = 3'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 24'(i + 7);
      #1;
      tests++;
      if (wr_en !== exp_rd[i]) begin
        fails++; $display("FAIL k1_wr[%0d] got=%b want=%b", i, wr_en, exp_rd[i]);
      end
      @(negedge clk);
    end
    ld_valid = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      tests++;
      if (rd_en !== exp_rd[t]) begin
        fails++; $display("FAIL k1_rd[t=%0d] got=%b want=%b", t, rd_en, exp_rd[t]);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (done !== (c == 2)) begin
        fails++; $display("FAIL k1_done_cycle[%0d] got=%b want=%b", c, done, c == 2);
      end
      @(negedge clk);
    end
    $display("[TB] test_k1 done");
  endtask

  // k_len = 0 and 5 are rejected with a single-cycle error pulse.
  task automatic test_err;
    logic [2:0] bad [2];
    bad = '{3'd0, 3'd5};
    for (int b = 0; b < 2; b++) begin
      start = 1'b1; k_len = bad[b];
      @(negedge clk);
      start = 1'b0;
      #1;
      tests++;
      if ({err, busy, wr_en, rd_en, ld_ready} !== 9'b100000000) begin
        fails++;
        $display("FAIL err_pulse[k=%0d] got err=%b busy=%b wr=%b rd=%b rdy=%b want err=1 rest 0",
                 bad[b], err, busy, wr_en, rd_en, ld_ready);
      end
      @(negedge clk);
      #1;
      tests++;
      if ({err, busy} !== 2'b00) begin
        fails++; $display("FAIL err_clear[k=%0d] got=%b want=00", bad[b], {err, busy});
      end
      @(negedge clk);
    end
    $display("[TB] test_err done");
  endtask

  // k_len = 2 with i_ld_valid toggling: only accepted words advance.
  task automatic test_stall;
    int acc;
    int waited;
    logic [2:0] exp_wr [6];
    exp_wr = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
    acc = 0;
    start = 1'b1; k_len = 3'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ld_valid = (c % 2 == 0); ld_data = 24'(c);
      #1;
      tests++;
      if (ld_valid) begin
        if (wr_en !== exp_wr[acc] || ld_ready !== 1'b1) begin
          fails++; $display("FAIL stall_wr[%0d] got=%b rdy=%b want=%b", acc, wr_en, ld_ready, exp_wr[acc]);
        end
        acc++;
      end else if (wr_en !== 3'b000 || ld_ready !== 1'b1) begin
        fails++; $display("FAIL stall_idle[c=%0d] got wr=%b rdy=%b want 000/1", c, wr_en, ld_ready);
      end
      @(negedge clk);
      if (acc == 6) break;
    end
    ld_valid = 1'b0;
    #1;
    tests++;
    if ({rd_en, ld_ready} !== 4'b0010) begin
      fails++; $display("FAIL stall_feed_entry got=%b want=0010", {rd_en, ld_ready});
    end
    waited = 0;
    while (done !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    tests++;
    if (done !== 1'b1 || waited != 6) begin
      fails++; $display("FAIL stall_done got done=%b after %0d cycles want 1 after 6", done, waited);
    end
    @(negedge clk);
    $display("[TB] test_stall done");
  endtask

  // Reset at FEED t = 2 aborts the job without o_done; a fresh job then works.
  task automatic test_reset_mid_feed;
    int done_seen;
    int waited;
    start = 1'b1; k_len = 3'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ld_valid = 1'b1; ld_data = 24'(i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (rd_en !== 3'b111) begin
      fails++; $display("FAIL rstmid_t2 got rd_en=%b want=111", rd_en);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if ({ld_ready, wr_en, rd_en, busy, done, err} !== 10'b0) begin
      fails++; $display("FAIL rstmid_outputs got=%b want=0", {ld_ready, wr_en, rd_en, busy, done, err});
    end
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    tests++;
    if (done_seen != 0) begin
      fails++; $display("FAIL rstmid_no_done got %0d busy/done cycles want 0", done_seen);
    end
    start = 1'b1; k_len = 3'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 24'(i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #1;
    waited = 0;
    while (done !== 1'b1 && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    tests++;
    if (done !== 1'b1 || waited != 5) begin
      fails++; $display("FAIL rstmid_fresh_done got done=%b after %0d want 1 after 5", done, waited);
    end
    @(negedge clk);
    $display("[TB] test_reset_mid_feed done");
  endtask

  // i_start held high: one job per IDLE sample, next job right after o_done.
  task automatic test_back_to_back;
    int waited;
    int jobs;
    start = 1'b1; k_len = 3'd1;
    jobs = 0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      #1;
      tests++;
      if ({busy, ld_ready} !== 2'b11) begin
        fails++; $display("FAIL b2b_load[%0d] got=%b want=11", j, {busy, ld_ready});
      end
      for (int i = 0; i < 3; i++) begin
        ld_valid = 1'b1; ld_data = 24'(i);
        @(negedge clk);
      end
      ld_valid = 1'b0;
      #1;
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
        @(negedge clk); #1; waited++;
      end
      if (done === 1'b1) jobs++;
      if (j == 1) start = 1'b0;
      @(negedge clk);
      #1;
      tests++;
      if (busy !== 1'b0) begin
        fails++; $display("FAIL b2b_idle_gap[%0d] got busy=%b want 0", j, busy);
      end
    end
    tests++;
    if (jobs != 2) begin
      fails++; $display("FAIL b2b_jobs got=%0d want=2", jobs);
    end
    @(negedge clk);
    #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL b2b_no_third got busy=%b want 0", busy);
    end
    $display("[TB] test_back_to_back done");
  endtask

  // Write and read strobes must never overlap.
  always @(negedge clk) begin
    #2;
    if (rst_n && wr_en !== 3'b000 && rd_en !== 3'b000) begin
      tests++;
      fails++;
      $display("FAIL strobe_overlap got wr=%b rd=%b want one of them 0", wr_en, rd_en);
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_k1();
    test_err();
    test_stall();
    test_reset_mid_feed();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
